// File: rtl/ccip_tx_flow_scheduler_pkg.sv
// Shared NIC definitions for the CCI-P TX flow scheduler: scheduler states,
// flow id type and the batch-length decode.
package ccip_tx_flow_scheduler_pkg;

  typedef enum logic [1:0] {
    SchIdle  = 2'd0,
    SchGrant = 2'd1,
    SchCool  = 2'd2
  } SchState;

  localparam int LMAX_NUM_OF_FLOWS_DEF = 1;
  typedef logic [LMAX_NUM_OF_FLOWS_DEF-1:0] FlowId;

  localparam int LBATCH_MAX = 2;

  // log2 batch size to entry count; anything above LBATCH_MAX clamps to it.
  function automatic int batch_len(input int l_batch);
    return (l_batch > LBATCH_MAX) ? (1 << LBATCH_MAX) : (1 << l_batch);
  endfunction

endpackage

// File: rtl/ccip_tx_flow_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request mask circularly
// starting at ptr and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/ccip_tx_flow_scheduler.sv
// Per-flow batch scheduler for the CCI-P TX path: counts unscheduled entries per
// flow and issues round-robin (flow, length) grants. Optional CCIP_TX_SCHED_TIMEOUT_EN.
module ccip_tx_flow_scheduler
  import ccip_tx_flow_scheduler_pkg::*;
#(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFLOW_DEPTH       = 3,
  parameter int LMAX_CCIP_BATCH   = 2,
  parameter int LTIMEOUT          = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
  input  logic                         push_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] push_flow_id,
  input  logic                         sRx_c1TxAlmFull,
  output logic                         grant_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] grant_flow_id,
  output logic [LMAX_CCIP_BATCH:0]     grant_len,
  input  logic                         grant_ready,
  output logic                         busy,
  output logic                         ovf
);

  localparam int NF = 1 << LMAX_NUM_OF_FLOWS;
  localparam int FW = LMAX_NUM_OF_FLOWS;
  localparam int OW = LFLOW_DEPTH + 1;
  localparam int LW = LMAX_CCIP_BATCH + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(1 << LFLOW_DEPTH);

  SchState state_reg, state_next;

  logic [NF-1:0][OW-1:0] occ_reg, occ_next;
  logic [NF-1:0]         in_range, full_ready, drop;
  logic [NF-1:0]         arb_req, arb_gnt;
  logic [FW-1:0]         arb_idx, rr_ptr;
  logic                  arb_any;

  logic [FW-1:0] last_grant_reg, last_grant_next;
  logic          grant_valid_reg, grant_valid_next;
  logic [FW-1:0] grant_flow_id_reg, grant_flow_id_next;
  logic [LW-1:0] grant_len_reg, grant_len_next;
  logic          ovf_reg;
  logic          grant_hs;

  logic [LW-1:0] batch, sel_len;
  logic [OW-1:0] batch_occ;

  assign batch     = LW'(batch_len(int'(l_tx_batch_size)));
  assign batch_occ = OW'(batch);

  for (genvar gi = 0; gi < NF; gi++) begin : g_flow
    logic push_f, hs_f, at_full;
    assign push_f         = push_valid && (push_flow_id == FW'(gi));
    assign hs_f           = grant_hs && (grant_flow_id_reg == FW'(gi));
    assign at_full        = (occ_reg[gi] == OCC_FULL);
    assign in_range[gi]   = (FW'(gi) <= number_of_flows);
    assign full_ready[gi] = in_range[gi] && (occ_reg[gi] >= batch_occ);
    // A handshake always frees room, so a same-cycle push is never dropped.
    assign occ_next[gi]   = hs_f ? (occ_reg[gi] + OW'(push_f) - OW'(grant_len_reg)) :
                            (push_f && !at_full) ? (occ_reg[gi] + OW'(1)) : occ_reg[gi];
    assign drop[gi]       = push_f && !hs_f && at_full;
  end

`ifdef CCIP_TX_SCHED_TIMEOUT_EN
  localparam int AW = LTIMEOUT + 1;

  logic [NF-1:0][AW-1:0] age_reg, age_next;
  logic [NF-1:0]         timed_ready;

  for (genvar gi = 0; gi < NF; gi++) begin : g_age
    logic partial;
    assign partial = (occ_reg[gi] != '0) && (occ_reg[gi] < batch_occ);
    // Age saturates once its top bit is set; any push or grant restarts it.
    assign age_next[gi] = (g_flow[gi].push_f || g_flow[gi].hs_f) ? '0 :
                          (partial && !age_reg[gi][LTIMEOUT]) ? (age_reg[gi] + AW'(1)) :
                          age_reg[gi];
    assign timed_ready[gi] = in_range[gi] && partial && age_reg[gi][LTIMEOUT];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      age_reg <= '0;
    end else begin
      age_reg <= age_next;
    end
  end

  assign arb_req = (|full_ready) ? full_ready : timed_ready;
  assign sel_len = (|full_ready) ? batch : LW'(1);
`else
  wire unused_timeout = ^32'(LTIMEOUT);

  assign arb_req = full_ready;
  assign sel_len = batch;
`endif

  assign rr_ptr = last_grant_reg + FW'(1);

  rr_arbiter #(
    .N  (NF),
    .IW (FW)
  ) u_rr_arbiter (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign arb_any = |arb_gnt;

  always_comb begin
    state_next         = state_reg;
    grant_valid_next   = grant_valid_reg;
    grant_flow_id_next = grant_flow_id_reg;
    grant_len_next     = grant_len_reg;
    last_grant_next    = last_grant_reg;
    grant_hs           = 1'b0;
    case (state_reg)
      SchIdle: begin
        if (start && !sRx_c1TxAlmFull && arb_any) begin
          state_next         = SchGrant;
          grant_valid_next   = 1'b1;
          grant_flow_id_next = arb_idx;
          grant_len_next     = sel_len;
        end
      end
      SchGrant: begin
        if (grant_ready) begin
          grant_hs         = 1'b1;
          grant_valid_next = 1'b0;
          last_grant_next  = grant_flow_id_reg;
          state_next       = SchCool;
        end
      end
      SchCool: state_next = SchIdle;
      default: state_next = SchIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg         <= SchIdle;
      occ_reg           <= '0;
      last_grant_reg    <= '1;
      grant_valid_reg   <= 1'b0;
      grant_flow_id_reg <= '0;
      grant_len_reg     <= '0;
      ovf_reg           <= 1'b0;
    end else begin
      state_reg         <= state_next;
      occ_reg           <= occ_next;
      last_grant_reg    <= last_grant_next;
      grant_valid_reg   <= grant_valid_next;
      grant_flow_id_reg <= grant_flow_id_next;
      grant_len_reg     <= grant_len_next;
      ovf_reg           <= ovf_reg | (|drop);
    end
  end

  assign grant_valid   = grant_valid_reg;
  assign grant_flow_id = grant_flow_id_reg;
  assign grant_len     = grant_len_reg;
  assign busy          = (state_reg != SchIdle);
  assign ovf           = ovf_reg;

endmodule

// File: doc/ccip_tx_flow_scheduler.md
# ccip_tx_flow_scheduler

Per-flow batch scheduler for the CCI-P TX path. It tracks how many requests each flow FIFO holds that have not yet been scheduled, and finds flows holding a full batch. It arbitrates round-robin among those flows and hands one `(flow, length)` grant at a time to the transmitter's pop sequencer. Grant issue is gated on CCI-P C1 almost-full, so a batch never starts while the channel is backpressured.

## Interface
- `LMAX_NUM_OF_FLOWS`, 1: log2 of the number of flows.
- `LFLOW_DEPTH`, 3: log2 of the per-flow FIFO depth; sets the occupancy counter range.
- `LMAX_CCIP_BATCH`, 2: width of the batch-size control.
- `LTIMEOUT`, 8: log2 of the partial-batch flush timeout in cycles; used only with the macro.

- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: enables scheduling.
- `number_of_flows` in LMAX_NUM_OF_FLOWS: highest active flow index.
- `l_tx_batch_size` in LMAX_CCIP_BATCH: log2 batch size; values 0..2 are legal, larger values are treated as 2.
- `push_valid` in 1: one entry enqueued into a flow FIFO this cycle.
- `push_flow_id` in LMAX_NUM_OF_FLOWS: the flow that received the entry.
- `sRx_c1TxAlmFull` in 1: CCI-P C1 almost-full.
- `grant_valid` out 1: grant offered.
- `grant_flow_id` out LMAX_NUM_OF_FLOWS: flow to pop.
- `grant_len` out LMAX_CCIP_BATCH+1: number of entries to pop (1, 2 or 4).
- `grant_ready` in 1: transmitter accepts the grant.
- `busy` out 1: state is not SchIdle.
- `ovf` out 1: sticky; a push arrived on a full flow.

## Operation
- `batch` = `1 << min(l_tx_batch_size, 2)`.
- `occ[f]` is a counter of width LFLOW_DEPTH+1 per flow:
  - +1 on a push to flow f.
  - −`grant_len` on a grant handshake for flow f.
  - Push and handshake on the same flow in the same cycle: net change is +1−`grant_len`.
  - Push while `occ[f]` = 2^LFLOW_DEPTH: count unchanged, `ovf` set until reset.
- `ready[f]` = (f ≤ `number_of_flows`) && (`occ[f]` ≥ `batch`).
- Flows above `number_of_flows` are never granted; their counts keep updating.
- State machine:
  - **SchIdle**: if `start` && !`sRx_c1TxAlmFull` && any `ready`, then:
    - pick the first ready flow in round-robin order, starting at `last_grant`+1 and wrapping past `number_of_flows` to 0;
    - register `grant_flow_id` and `grant_len` = `batch`, assert `grant_valid`;
    - go to SchGrant.
  - **SchGrant**:
    - `grant_valid`, `grant_flow_id` and `grant_len` are held stable until `grant_ready`; they are never retracted, even if `start` falls or almost-full rises.
    - On handshake: update `occ`, set `last_grant` to the granted flow, deassert `grant_valid`, go to SchCool.
  - **SchCool**: one cycle so updated counts settle, then go to SchIdle.
- Changing `l_tx_batch_size` during SchGrant has no effect on the outstanding `grant_len`.
- Reset (asserted any time): all state cleared immediately; an in-flight grant is dropped.

## Timing
- Reset values:
  - `grant_valid` = 0, `grant_flow_id` = 0, `grant_len` = 0, `busy` = 0, `ovf` = 0;
  - all `occ` = 0, `last_grant` = all-ones so flow 0 is first, state SchIdle.
- A push at edge n is counted in `occ` at edge n; the earliest resulting `grant_valid` is high after edge n+1.
- If the handshake happens at edge m: SchCool for cycle m→m+1, SchIdle evaluates m+1→m+2, earliest next `grant_valid` after edge m+2. Maximum rate is one grant every 3 cycles plus the handshake wait.
- Almost-full is sampled only in SchIdle.

## Configuration
- `CCIP_TX_SCHED_TIMEOUT_EN` defined:
  - per-flow age counters of width LTIMEOUT+1, cleared on any push or grant to that flow;
  - each counter increments while 0 < `occ[f]` < `batch`;
  - at 2^LTIMEOUT the flow becomes ready with `grant_len` = 1 (single-line flush);
  - full-batch flows take priority over timed-out flows.
- Not defined: no age counters; partial batches wait indefinitely.

## Structure
- `SchState` enum, `FlowId` typedef and the batch-length decode belong in the shared NIC defs package.
- One combinational sub-module, `rr_arbiter`: request mask plus pointer in, one-hot grant and encoded index out, parameterized by width.

## Test plan
- Batch size 4, flows 0..1, four pushes to flow 1 → `grant_valid` with flow 1, len 4, two edges after the last push; `occ[1]` = 0 after handshake.
- Flows 0 and 1 both at `occ` 2, batch 2, `grant_ready` tied high → grants alternate 0, 1, 0, 1.
- Almost-full high with flow 0 ready → no grant; almost-full deasserted → grant after 1 edge. Almost-full raised during SchGrant → grant held and still accepted.
- Nine pushes to flow 0 with LFLOW_DEPTH 3 → `ovf` = 1, `occ[0]` = 8. A push plus a handshake on flow 0 in the same cycle at batch 2 → `occ` 8→7.
- `resetn` low while `grant_valid` = 1 → `grant_valid` drops without waiting for a clock; counts are 0 after release.
- With `CCIP_TX_SCHED_TIMEOUT_EN`, LTIMEOUT 3, batch 4, one push → grant of len 1 after 8 idle cycles.
